// File: rtl/stream_mux_pkg.sv
// Shared mode encodings for the registered round-robin stream mux.
package stream_mux_pkg;
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search: first requester after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  int            c;
  logic [SW-1:0] ci;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    ci        = '0;
    // k runs 1..N so the last granted channel is considered last
    for (int k = 1; k <= N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      ci = SW'(c);
      if (!gnt_valid && req[ci]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ci;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream mux, round-robin or fixed select, into one output register.
// Latency: 1 cycle from input accept to out_valid; full rate with out_ready high.
// Backpressure: in_ready is all zeros while the output word is stalled.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] ptr;
  logic          load;
  logic          rr_valid;
  logic [SW-1:0] rr_idx;
  logic          fixed_valid;
  logic          gnt_valid;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  assign load = !out_valid || out_ready;

  // sel values >= N never match a channel, so they yield no grant
  always_comb begin
    fixed_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i) && in_valid[i]) fixed_valid = 1'b1;
    end
  end

  always_comb begin
    if (mode == MODE_FIXED) begin
      gnt_valid = fixed_valid;
      gnt_idx   = sel;
    end else begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) begin
        gnt_data    = in_data[i*W +: W];
        in_ready[i] = load && gnt_valid && !rst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SW'(N - 1);
    end else if (load) begin
      if (gnt_valid) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_chan  <= gnt_idx;
        ptr       <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with N=4, W=8 and fixed channel words A0..A3.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".data"}, {24'd0, out_data}, {24'd0, d});
    chk({tag, ".chan"}, {30'd0, out_chan}, {30'd0, c});
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;

    // Reset held two cycles with every channel requesting
    step();
    chk("rst.in_ready", {28'd0, in_ready}, 32'h0);
    chk_out("rst.c1", 1'b0, 8'h00, 2'd0);
    step();
    chk("rst.in_ready2", {28'd0, in_ready}, 32'h0);
    chk_out("rst.c2", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", {28'd0, in_ready}, 32'h1);
    step();
    chk_out("rel.first", 1'b1, 8'hA0, 2'd0);

    // Round-robin with all channels valid: 1,2,3,0,1
    chk("rr.in_ready1", {28'd0, in_ready}, 32'h2);
    step(); chk_out("rr.1", 1'b1, 8'hA1, 2'd1);
    step(); chk_out("rr.2", 1'b1, 8'hA2, 2'd2);
    step(); chk_out("rr.3", 1'b1, 8'hA3, 2'd3);
    step(); chk_out("rr.0", 1'b1, 8'hA0, 2'd0);
    step(); chk_out("rr.1b", 1'b1, 8'hA1, 2'd1);

    // Backpressure: A1 held three cycles, nothing accepted
    out_ready = 1'b0;
    #1;
    chk("bp.in_ready0", {28'd0, in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bp.hold", 1'b1, 8'hA1, 2'd1);
      chk("bp.in_ready", {28'd0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.resume_rdy", {28'd0, in_ready}, 32'h4);
    step();
    chk_out("bp.resume", 1'b1, 8'hA2, 2'd2);

    // Sparse round-robin: only channels 1 and 3 request, ptr=2
    in_valid = 4'b1010;
    #1;
    chk("sp.rdy3", {28'd0, in_ready}, 32'h8);
    step(); chk_out("sp.3", 1'b1, 8'hA3, 2'd3);
    chk("sp.rdy1", {28'd0, in_ready}, 32'h2);
    step(); chk_out("sp.1", 1'b1, 8'hA1, 2'd1);
    chk("sp.rdy3b", {28'd0, in_ready}, 32'h8);
    step(); chk_out("sp.3b", 1'b1, 8'hA3, 2'd3);
    chk("sp.rdy1b", {28'd0, in_ready}, 32'h2);
    step(); chk_out("sp.1b", 1'b1, 8'hA1, 2'd1);

    // Fixed select on channel 2
    mode     = 1'b1;
    sel      = 2'd2;
    in_valid = 4'b1111;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("fx.rdy", {28'd0, in_ready}, 32'h4);
      step();
      chk_out("fx.out", 1'b1, 8'hA2, 2'd2);
    end
    in_valid = 4'b1011;
    #1;
    chk("fx.norq_rdy", {28'd0, in_ready}, 32'h0);
    step();
    chk_out("fx.drop", 1'b0, 8'hA2, 2'd2);

    // Back to round-robin with the consumer stalled: empty register still loads
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    chk("sw.rdy", {28'd0, in_ready}, 32'h8);
    step();
    chk_out("sw.3", 1'b1, 8'hA3, 2'd3);
    chk("sw.stall_rdy", {28'd0, in_ready}, 32'h0);

    // Reset while a word is held
    rst = 1'b1;
    #1;
    chk("mr.rdy", {28'd0, in_ready}, 32'h0);
    step();
    chk_out("mr.cleared", 1'b0, 8'h00, 2'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr.rel_rdy", {28'd0, in_ready}, 32'h1);
    step();
    chk_out("mr.first", 1'b1, 8'hA0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
